ascon_dec_unwrap: RTL

//  ASCON-128 decryption data phase + finalization: the receive-side counterpart of the encrypt-side absorb XOR.

---
 rtl/ascon_dec_unwrap_pkg.sv | 18 +
 rtl/ascon_dec_unwrap_if.sv | 26 ++
 rtl/ascon_dec_unwrap_lastblk.sv | 33 +++
 rtl/ascon_dec_unwrap.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/ascon_dec_unwrap_pkg.sv
// rtl/ascon_dec_unwrap_pkg.sv - shared state type, pad constant and FSM encoding for the ASCON-128 decrypt unwrap
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    localparam logic [7:0] ASCON_PAD_BYTE = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_C,
        ST_OUT_P,
        ST_PERM_D,
        ST_FIN_XOR,
        ST_PERM_F,
        ST_CHECK
    } type_dec_fsm;

endpackage

// File: rtl/ascon_dec_unwrap_if.sv
// rtl/ascon_dec_unwrap_if.sv - ciphertext-in / plaintext-out beat streams of the ASCON-128 decrypt unwrap
interface ascon_dec_unwrap_if;

    logic [63:0] cipher_i;
    logic [3:0]  cipher_bytes_i;
    logic        cipher_last_i;
    logic        cipher_valid_i;
    logic        cipher_ready_o;

    logic [63:0] plain_o;
    logic [3:0]  plain_bytes_o;
    logic        plain_last_o;
    logic        plain_valid_o;
    logic        plain_ready_i;

    modport slave (
        input  cipher_i, cipher_bytes_i, cipher_last_i, cipher_valid_i, plain_ready_i,
        output cipher_ready_o, plain_o, plain_bytes_o, plain_last_o, plain_valid_o
    );

    modport master (
        output cipher_i, cipher_bytes_i, cipher_last_i, cipher_valid_i, plain_ready_i,
        input  cipher_ready_o, plain_o, plain_bytes_o, plain_last_o, plain_valid_o
    );

endinterface

// File: rtl/ascon_dec_unwrap_lastblk.sv
// rtl/ascon_dec_unwrap_lastblk.sv - combinational ciphertext XOR, byte mask and 0x80 padding for one beat
module ascon_dec_lastblk
    import ascon_pack::*;
(
    input  logic [63:0] i_s0,
    input  logic [63:0] i_cipher,
    input  logic [3:0]  i_bytes,
    input  logic        i_last,
    output logic [63:0] o_plain,
    output logic [63:0] o_s0_next,
    output logic [3:0]  o_bytes
);

    logic [6:0]  w_shift;
    logic [63:0] w_mask;
    logic [63:0] w_pad;

    // Mask keeps the top l bytes; a count of 8 shifts everything out and leaves a full-width mask.
    always_comb begin
        w_shift = {i_bytes, 3'b000};
        w_mask  = '1;
        w_pad   = '0;
        o_bytes = 4'd8;
        if (i_last) begin
            w_mask  = ~(64'hFFFF_FFFF_FFFF_FFFF >> w_shift);
            w_pad   = {ASCON_PAD_BYTE, 56'h0} >> w_shift;
            o_bytes = i_bytes;
        end
        o_plain   = (i_s0 ^ i_cipher) & w_mask;
        o_s0_next = (i_cipher & w_mask) | ((i_s0 & ~w_mask) ^ w_pad);
    end

endmodule

// File: rtl/ascon_dec_unwrap.sv
// rtl/ascon_dec_unwrap.sv - ASCON-128 decrypt data phase and tag check; ASCON_DEC_ZEROIZE_EN clears state after done
module ascon_dec_unwrap
    import ascon_pack::*;
#(
    parameter int unsigned DATA_ROUNDS = 6,
    parameter int unsigned FIN_ROUNDS  = 12,
    parameter int unsigned CNT_W       = 16
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  type_state          state_i,
    input  logic [127:0]       key_i,
    input  logic [127:0]       tag_i,
    ascon_dec_unwrap_if.slave  bus,
    output logic               perm_start_o,
    output logic [3:0]         perm_rounds_o,
    output type_state          perm_state_o,
    input  type_state          perm_state_i,
    input  logic               perm_done_i,
    output logic [CNT_W-1:0]   blk_count_o,
    output logic               done_o,
    output logic               tag_ok_o,
    output type_state          state_o
);

    type_dec_fsm      r_fsm, w_fsm_next;
    type_state        r_state;
    logic [127:0]     r_key, r_tag;
    logic [63:0]      r_plain;
    logic [3:0]       r_plain_bytes;
    logic             r_plain_last, r_plain_valid, r_perm_start, r_tag_ok;
    logic [CNT_W-1:0] r_blk_count;

    logic             w_accept, w_plain_hs, w_perm_take, w_check, w_match;
    logic [63:0]      w_plain, w_s0_next;
    logic [3:0]       w_bytes;
    logic [127:0]     w_tag_calc;

    ascon_dec_lastblk u_lastblk (
        .i_s0      (r_state[0]),
        .i_cipher  (bus.cipher_i),
        .i_bytes   (bus.cipher_bytes_i),
        .i_last    (bus.cipher_last_i),
        .o_plain   (w_plain),
        .o_s0_next (w_s0_next),
        .o_bytes   (w_bytes)
    );

    assign w_tag_calc = {r_state[3] ^ r_key[127:64], r_state[4] ^ r_key[63:0]};
    assign w_match    = ~|(w_tag_calc ^ r_tag);

    always_ff @(posedge clock_i) begin
        if (reset_i) r_fsm <= ST_IDLE;
        else         r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next         = r_fsm;
        w_accept           = 1'b0;
        w_plain_hs         = 1'b0;
        w_perm_take        = 1'b0;
        w_check            = 1'b0;
        perm_rounds_o      = 4'd0;
        bus.cipher_ready_o = 1'b0;
        case (r_fsm)
            ST_IDLE:    if (start_i) w_fsm_next = ST_WAIT_C;
            ST_WAIT_C: begin
                bus.cipher_ready_o = 1'b1;
                if (bus.cipher_valid_i) begin
                    w_accept   = 1'b1;
                    w_fsm_next = ST_OUT_P;
                end
            end
            ST_OUT_P: if (bus.plain_ready_i) begin
                w_plain_hs = 1'b1;
                w_fsm_next = r_plain_last ? ST_FIN_XOR : ST_PERM_D;
            end
            ST_PERM_D: begin
                perm_rounds_o = 4'(DATA_ROUNDS);
                if (perm_done_i) begin
                    w_perm_take = 1'b1;
                    w_fsm_next  = ST_WAIT_C;
                end
            end
            ST_FIN_XOR: w_fsm_next = ST_PERM_F;
            ST_PERM_F: begin
                perm_rounds_o = 4'(FIN_ROUNDS);
                if (perm_done_i) begin
                    w_perm_take = 1'b1;
                    w_fsm_next  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_check    = 1'b1;
                w_fsm_next = ST_IDLE;
            end
            default:    w_fsm_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state       <= '0;
            r_key         <= '0;
            r_tag         <= '0;
            r_plain       <= '0;
            r_plain_bytes <= '0;
            r_plain_last  <= 1'b0;
            r_plain_valid <= 1'b0;
            r_perm_start  <= 1'b0;
            r_tag_ok      <= 1'b0;
            r_blk_count   <= '0;
        end else begin
            r_perm_start <= 1'b0;
            if (r_fsm == ST_IDLE && start_i) begin
                r_state     <= state_i;
                r_key       <= key_i;
                r_tag       <= tag_i;
                r_blk_count <= '0;
                r_tag_ok    <= 1'b0;
            end
            if (w_accept) begin
                r_state[0]    <= w_s0_next;
                r_plain       <= w_plain;
                r_plain_bytes <= w_bytes;
                r_plain_last  <= bus.cipher_last_i;
                r_plain_valid <= 1'b1;
                r_blk_count   <= r_blk_count + CNT_W'(1);
            end
            if (w_plain_hs) begin
                r_plain_valid <= 1'b0;
                r_perm_start  <= ~r_plain_last;
            end
            // Key goes into S1/S2 one cycle ahead so the permutation request sees the finalization input.
            if (r_fsm == ST_FIN_XOR) begin
                r_state[1]   <= r_state[1] ^ r_key[127:64];
                r_state[2]   <= r_state[2] ^ r_key[63:0];
                r_perm_start <= 1'b1;
            end
            if (w_perm_take) r_state <= perm_state_i;
            if (w_check) begin
                r_tag_ok <= w_match;
`ifdef ASCON_DEC_ZEROIZE_EN
                r_state  <= '0;
`endif
            end
        end
    end

    assign bus.plain_o       = r_plain;
    assign bus.plain_bytes_o = r_plain_bytes;
    assign bus.plain_last_o  = r_plain_last;
    assign bus.plain_valid_o = r_plain_valid;
    assign perm_start_o      = r_perm_start;
    assign perm_state_o      = r_state;
    assign state_o           = r_state;
    assign blk_count_o       = r_blk_count;
    assign done_o            = w_check;
    assign tag_ok_o          = w_check ? w_match : r_tag_ok;

endmodule
